// File: rtl/imem_pkg.sv
// imem_pkg: shared widths and FSM state encoding for the instruction-memory responder
package imem_pkg;
  localparam int WORD_W = 16;
  localparam int CNT_W = 3;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t WAIT = 2'd1;
  localparam state_t RESP = 2'd2;
endpackage

// File: rtl/imem_array.sv
// imem_array: instruction word storage with async read and sync preload write
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [DEPTH_WORDS];
  assign rdata = mem[raddr];
  // preload write; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
endmodule

// File: rtl/imem_responder.sv
// imem_responder: fixed-latency instruction fetch responder with error flagging, flush and preload
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reqValid,
  input  logic [WORD_W-1:0] reqAddr,
  output logic              reqReady,
  output logic              respValid,
  input  logic              respReady,
  output logic [WORD_W-1:0] respData,
  output logic              respErr,
  input  logic              flush,
  input  logic              loadEn,
  input  logic [WORD_W-1:0] loadAddr,
  input  logic [WORD_W-1:0] loadData
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [WORD_W-1:0] LIM = WORD_W'(DEPTH_WORDS);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [WORD_W-1:0] data_q, rd_data;
  logic err_q, accept, req_err, ld_ok, unused_ok;
  assign req_err = reqAddr[0] | ({1'b0, reqAddr[WORD_W-1:1]} >= LIM);
  assign ld_ok = {1'b0, loadAddr[WORD_W-1:1]} < LIM;
  assign unused_ok = loadAddr[0];
  assign reqReady = (state == IDLE) & ~loadEn;
  assign accept = reqValid & reqReady;
  assign respValid = state == RESP;
  assign respData = data_q;
  assign respErr = err_q;
  imem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk  (clk),
    .we   (loadEn & ld_ok),
    .waddr(loadAddr[AW:1]),
    .wdata(loadData),
    .raddr(reqAddr[AW:1]),
    .rdata(rd_data)
  );
  // request FSM: capture data at acceptance, count down the latency, hold until consumed or flushed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      data_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          data_q <= req_err ? '0 : rd_data;
          err_q <= req_err;
          cnt <= CNT_W'(LATENCY - 1);
          state <= (LATENCY > 1) ? WAIT : RESP;
        end
        WAIT: begin
          cnt <= (cnt != '0) ? cnt - 1'b1 : cnt;
          state <= flush ? IDLE : (cnt[CNT_W-1:1] == '0) ? RESP : WAIT;
        end
        RESP: state <= (flush | respReady) ? IDLE : RESP;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: randomized scoreboard bench against a behavioural memory/latency model
module tb_imem_responder;
  localparam int DW = 256;
  localparam int LAT = 2;
  typedef struct packed {logic [15:0] d; logic e;} exp_t;
  logic clk = 0, rst_n = 0;
  logic reqValid = 0, respReady = 0, flush = 0, loadEn = 0;
  logic [15:0] reqAddr = 0, loadAddr = 0, loadData = 0;
  logic reqReady, respValid, respErr;
  logic [15:0] respData;
  exp_t q[$];
  logic [15:0] mem_m [DW];
  bit busy = 0;
  int cyc = 0, acc = 0, vecs = 0, errs = 0;

  imem_responder #(.DEPTH_WORDS(DW), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .reqValid(reqValid), .reqAddr(reqAddr), .reqReady(reqReady),
    .respValid(respValid), .respReady(respReady), .respData(respData), .respErr(respErr),
    .flush(flush), .loadEn(loadEn), .loadAddr(loadAddr), .loadData(loadData)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at t=%0t", n, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_read(input logic [15:0] a);
    exp_t x;
    x.e = a[0] || (int'(a >> 1) >= DW);
    x.d = x.e ? 16'h0000 : mem_m[int'(a >> 1)];
    return x;
  endfunction

  // reference model: one request in flight, response visible LAT-1 edges after acceptance
  always @(posedge clk) begin
    bit wb, rp;
    if (!rst_n) begin
      busy = 0;
      q.delete();
    end else begin
      wb = busy;
      rp = busy && (cyc >= acc + LAT - 1);
      if (busy && flush) begin
        busy = 0;
        if (q.size() > 0) q.delete(0);
      end else if (rp && respReady) busy = 0;
      cyc++;
      if (!wb && reqValid && !loadEn) begin
        q.push_back(ref_read(reqAddr));
        busy = 1;
        acc = cyc;
      end
      if (loadEn && int'(loadAddr >> 1) < DW) mem_m[int'(loadAddr >> 1)] = loadData;
    end
  end

  // monitor: compare handshake outputs against the model each cycle, pop on consumption
  always @(negedge clk) begin
    if (rst_n) begin
      chk("respValid", {15'd0, respValid}, {15'd0, busy && (cyc >= acc + LAT - 1)});
      chk("reqReady", {15'd0, reqReady}, {15'd0, !busy && !loadEn});
      if (respValid) begin
        if (q.size() == 0) chk("resp_without_request", 16'd1, 16'd0);
        else begin
          chk("respData", respData, q[0].d);
          chk("respErr", {15'd0, respErr}, {15'd0, q[0].e});
          if (respReady && !flush) q.delete(0);
        end
      end
    end
  end

  task automatic step(input logic rv, input logic [15:0] ra, input logic rr, input logic fl,
                      input logic le, input logic [15:0] la, input logic [15:0] ld);
    @(posedge clk);
    #1;
    reqValid = rv; reqAddr = ra; respReady = rr; flush = fl;
    loadEn = le; loadAddr = la; loadData = ld;
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) step(0, 0, rr, 0, 0, 0, 0);
  endtask

  initial begin
    int k;
    logic [15:0] a;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_respValid", {15'd0, respValid}, 16'd0);
    chk("rst_respData", respData, 16'd0);
    chk("rst_respErr", {15'd0, respErr}, 16'd0);
    rst_n = 1;
    for (int i = 0; i < DW; i++) step(0, 0, 1, 0, 1, 16'(i * 2), 16'($urandom));
    step(0, 0, 1, 0, 1, 16'h0006, 16'hA5C3);
    step(1, 16'h0006, 1, 0, 0, 0, 0);
    idle(5, 1);
    step(1, 16'h0007, 1, 0, 0, 0, 0);
    idle(5, 1);
    step(1, 16'(2 * DW), 1, 0, 0, 0, 0);
    idle(5, 1);
    step(1, 16'h0006, 0, 0, 0, 0, 0);
    idle(5, 0);
    idle(4, 1);
    step(1, 16'h0006, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0);
    idle(4, 1);
    step(1, 16'h0000, 1, 0, 0, 0, 0);
    idle(5, 1);
    step(1, 16'h0006, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 16'h0006, 16'hFFFF);
    idle(4, 1);
    step(1, 16'h0006, 1, 0, 0, 0, 0);
    idle(5, 1);
    for (int i = 0; i < 3000; i++) begin
      k = int'($urandom % 8);
      a = (k < 6) ? {7'd0, 8'($urandom % DW), 1'b0} :
          (k == 6) ? {7'd0, 8'($urandom % DW), 1'b1} :
          {15'($urandom_range(DW, 32767)), 1'b0};
      step(1'($urandom % 2), a, ($urandom % 10) < 7, ($urandom % 10) == 0,
           ($urandom % 10) == 0, 16'($urandom), 16'($urandom));
    end
    idle(6, 1);
    step(1, 16'h0006, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    k = 0;
    while (!respValid && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!respValid) chk("timeout_respValid", 16'd0, 16'd1);
    #2;
    rst_n = 0;
    busy = 0;
    q.delete();
    #1;
    chk("async_rst_respValid", {15'd0, respValid}, 16'd0);
    chk("async_rst_respData", respData, 16'd0);
    chk("async_rst_respErr", {15'd0, respErr}, 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_reqReady", {15'd0, reqReady}, 16'd1);
    idle(3, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
